// File: rtl/irq_pkg.sv
// Shared types for the interrupt request front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irq_pkg;

  localparam int IRQ_N   = 8;
  localparam int IRQ_IDW = 3;

  typedef logic [IRQ_N-1:0]   irq_vec_t;
  typedef logic [IRQ_IDW-1:0] irq_id_t;

  // Presentation handshake states.
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PRESENT = 2'd1,
    IRQ_SETTLE  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises one async request line and flags its synced 0->1 transition.
// Latency: level valid SYNC_STAGES clk after req; rise is combinational off the flops.
// Backpressure: none; every synced rising edge produces exactly one rise cycle.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   req         raw asynchronous request line
//   level       synchronised request level
//   rise        high for one cycle after a synced 0->1 transition
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  // Edge is taken against the previous synced sample, never the raw line.
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Latches synced request edges into pending bits and presents one encoder-chosen ID at a time.
// Latency: req rise -> pending +SYNC_STAGES+1 clk -> pend +1 clk -> int_valid +1 clk.
// Backpressure: int_id held until int_ack; at most one ID per 3 clk; unacked edges pile into ovf.
//
// Ports:
//   clk, rst_n          clock and async active-low reset
//   req[N]              raw async request lines
//   mask[N]             1 = line enabled; gates pend only, capture is unaffected
//   pend[N]             registered pending & mask, drives the external encoder
//   enc_y, enc_valid    encoder result computed from pend
//   int_valid, int_id   presented interrupt ID
//   int_ack             consumer accept, honoured only while int_valid=1
//   ovf[N], ovf_clr[N]  sticky overflow flags, write-1-to-clear
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int N           = IRQ_N,
  parameter int IDW         = IRQ_IDW,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   pend,
  input  logic [IDW-1:0] enc_y,
  input  logic           enc_valid,
  output logic           int_valid,
  output logic [IDW-1:0] int_id,
  input  logic           int_ack,
  output logic [N-1:0]   ovf,
  input  logic [N-1:0]   ovf_clr
);

  logic [N-1:0] lvl;
  logic [N-1:0] rise;
  logic [N-1:0] pending;
  logic [N-1:0] clr;
  logic [N-1:0] ovf_set;
  irq_state_t   state;

  for (genvar i = 0; i < N; i++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  // Accepted ack clears the presented bit; only PRESENT can accept, so a
  // held ack cannot clear twice.
  always_comb begin
    clr     = '0;
    ovf_set = '0;
    if (EDGE_MODE != 0) begin
      if (state == IRQ_PRESENT && int_ack)
        clr = {{(N-1){1'b0}}, 1'b1} << int_id;
      // A clear in the same cycle consumes the old edge, so the new one is not an overflow.
      ovf_set = rise & pending & ~clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      pend    <= '0;
      ovf     <= '0;
    end else begin
      if (EDGE_MODE != 0)
        pending <= (pending & ~clr) | rise;   // set wins over clear
      else
        pending <= lvl;
      pend <= pending & mask;
      ovf  <= (ovf & ~ovf_clr) | ovf_set;     // set wins over ovf_clr
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IRQ_IDLE;
      int_valid <= 1'b0;
      int_id    <= '0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (enc_valid) begin
            int_id    <= enc_y;
            int_valid <= 1'b1;
            state     <= IRQ_PRESENT;
          end
        end
        IRQ_PRESENT: begin
          // int_id stays frozen here regardless of mask/pend movement.
          if (int_ack) begin
            int_valid <= 1'b0;
            state     <= IRQ_SETTLE;
          end
        end
        IRQ_SETTLE: begin
          // Lets pend drop the cleared bit before the encoder is sampled again.
          state <= IRQ_IDLE;
        end
        default: begin
          int_valid <= 1'b0;
          state     <= IRQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;

  // Edge-mode instance
  logic [7:0] req, mask, pend, ovf, ovf_clr;
  logic [2:0] enc_y, int_id;
  logic       enc_valid, int_valid, int_ack;

  // Level-mode instance
  logic [7:0] l_req, l_mask, l_pend, l_ovf, l_ovf_clr;
  logic [2:0] l_enc_y, l_int_id;
  logic       l_enc_valid, l_int_valid, l_int_ack;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] sb[$];
  logic [2:0] l_sb[$];

  always #5 clk = ~clk;

  // Reference 8:3 encoder: highest set index wins.
  function automatic logic [3:0] enc8(input logic [7:0] a);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 0; i < 8; i++)
      if (a[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  always_comb {enc_valid, enc_y}     = enc8(pend);
  always_comb {l_enc_valid, l_enc_y} = enc8(l_pend);

  irq_pending_latch #(.N(8), .IDW(3), .SYNC_STAGES(2), .EDGE_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .pend(pend),
    .enc_y(enc_y), .enc_valid(enc_valid), .int_valid(int_valid),
    .int_id(int_id), .int_ack(int_ack), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  irq_pending_latch #(.N(8), .IDW(3), .SYNC_STAGES(2), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .req(l_req), .mask(l_mask), .pend(l_pend),
    .enc_y(l_enc_y), .enc_valid(l_enc_valid), .int_valid(l_int_valid),
    .int_id(l_int_id), .int_ack(l_int_ack), .ovf(l_ovf), .ovf_clr(l_ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (int_valid !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    if (int_valid !== 1'b1) chk({tag, "_timeout"}, 32'(int_valid), 1);
  endtask

  // Pop the next expected ID when the DUT presents one.
  task automatic chk_id(input string tag);
    logic [2:0] e;
    wait_vld(tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_depth"}, 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    chk(tag, 32'(int_id), 32'(e));
  endtask

  task automatic do_ack;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; mask = 8'hFF; ovf_clr = '0; int_ack = 1'b0;
    l_req = '0; l_mask = 8'hFF; l_ovf_clr = '0; l_int_ack = 1'b0;

    // Reset state
    tick(2);
    chk("rst_vld",  32'(int_valid), 0);
    chk("rst_id",   32'(int_id),    0);
    chk("rst_pend", 32'(pend),      0);
    chk("rst_ovf",  32'(ovf),       0);
    rst_n = 1'b1;
    tick(2);

    // Single request, exact latency, no re-issue after ack
    sb.push_back(3'd4);
    req = 8'h10;
    tick(1);
    req = 8'h00;
    tick(3);
    chk("single_early", 32'(int_valid), 0);
    tick(1);
    chk("single_vld", 32'(int_valid), 1);
    chk_id("single_id");
    chk("single_pend", 32'(pend), 32'h10);
    do_ack;
    chk("single_drop", 32'(int_valid), 0);
    tick(1);
    chk("single_pend_clr", 32'(pend), 0);
    tick(6);
    chk("single_noreissue", 32'(int_valid), 0);

    // Priority 7 before 0
    sb.push_back(3'd7);
    sb.push_back(3'd0);
    req = 8'h81;
    tick(1);
    req = 8'h00;
    chk_id("prio_hi");
    chk("prio_pend81", 32'(pend), 32'h81);
    do_ack;
    tick(1);
    chk("prio_pend01", 32'(pend), 32'h01);
    chk_id("prio_lo");
    do_ack;
    tick(1);
    chk("prio_pend00", 32'(pend), 0);

    // Overflow: two edges on bit 2 without ack
    sb.push_back(3'd2);
    req = 8'h04; tick(2); req = 8'h00; tick(3);
    req = 8'h04; tick(2); req = 8'h00; tick(4);
    chk("ovf_set", 32'(ovf), 32'h04);
    chk_id("ovf_id");
    ovf_clr = 8'h04;
    tick(1);
    ovf_clr = 8'h00;
    chk("ovf_clr", 32'(ovf), 0);
    // Edge on bit 2 lands on the same clock as the ack of bit 2
    req = 8'h04;
    tick(1);
    req = 8'h00;
    tick(1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    chk("same_ovf", 32'(ovf), 0);
    sb.push_back(3'd2);
    tick(1);
    chk("same_pend", 32'(pend), 32'h04);
    chk_id("same_repres");
    do_ack;
    tick(1);
    chk("same_pend_clr", 32'(pend), 0);
    chk("same_ovf_end", 32'(ovf), 0);

    // Mask: bit 2 masked, bit 1 wins; unmask during PRESENT, then mask during PRESENT
    mask = 8'hFB;
    sb.push_back(3'd1);
    sb.push_back(3'd2);
    req = 8'h06;
    tick(1);
    req = 8'h00;
    chk_id("mask_lo");
    chk("mask_pend", 32'(pend), 32'h02);
    mask = 8'hFF;
    tick(2);
    chk("mask_hold_id",  32'(int_id),    1);
    chk("mask_hold_vld", 32'(int_valid), 1);
    do_ack;
    chk_id("mask_unmask");
    mask = 8'hFB;
    tick(3);
    chk("mask_frozen_id",  32'(int_id),    2);
    chk("mask_frozen_vld", 32'(int_valid), 1);
    do_ack;
    mask = 8'hFF;
    tick(3);
    chk("mask_pend_clr", 32'(pend),      0);
    chk("mask_idle",     32'(int_valid), 0);

    // Level mode: held request repeats every 3 clk while ack held high
    for (int r = 0; r < 3; r++) l_sb.push_back(3'd5);
    l_req = 8'h20;
    begin
      int n = 0;
      while (l_int_valid !== 1'b1 && n < 40) begin
        tick(1);
        n++;
      end
      if (l_int_valid !== 1'b1) chk("lvl_timeout", 32'(l_int_valid), 1);
    end
    l_int_ack = 1'b1;
    for (int r = 0; r < 3; r++) begin
      logic [2:0] e;
      e = l_sb.pop_front();
      chk("lvl_vld", 32'(l_int_valid), 1);
      chk("lvl_id",  32'(l_int_id),    32'(e));
      tick(1);
      chk("lvl_gap1", 32'(l_int_valid), 0);
      tick(1);
      chk("lvl_gap2", 32'(l_int_valid), 0);
      tick(1);
    end
    l_req = 8'h00;
    tick(10);
    l_int_ack = 1'b0;
    tick(3);
    chk("lvl_pend_drop", 32'(l_pend),      0);
    chk("lvl_idle",      32'(l_int_valid), 0);
    chk("lvl_ovf",       32'(l_ovf),       0);

    // Async reset in the middle of a presentation
    req = 8'h01; tick(2); req = 8'h00; tick(3);
    req = 8'h01; tick(2); req = 8'h00; tick(4);
    wait_vld("rst_pre");
    chk("rst_pre_ovf", 32'(ovf), 32'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_vld",  32'(int_valid), 0);
    chk("rst_async_id",   32'(int_id),    0);
    chk("rst_async_pend", 32'(pend),      0);
    chk("rst_async_ovf",  32'(ovf),       0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rst_dropped", 32'(int_valid), 0);

    chk("sb_drain",   32'(sb.size()),   0);
    chk("l_sb_drain", 32'(l_sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
